calc_sequencer: RTL and testbench

Sequential controller for the 4-bit add/subtract calculator datapath with validity checker.
- Collects operand A, operand B and the operation from switches, qualified by one-cycle enter pulses.
- Drives the combinational datapath, waits a fixed settle time, then latches the result and its validity flag.
- Holds the result for display, or enters a blinking error state when the result is invalid.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_tick_cnt.sv | 37 +++
 rtl/calc_sequencer.sv | 177 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and sizing for the calculator sequencer.
package calc_pkg;
  localparam int CALC_W        = 4;
  localparam int BLINK_DIV_MAX = 25000000;
  localparam int CNT_W         = $clog2(BLINK_DIV_MAX + 1);
  localparam int SETTLE_W      = 4;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    ISSUE,
    CAPTURE,
    SHOW,
    ERR
  } calc_state_t;

  function automatic logic is_busy(calc_state_t s);
    return (s == ISSUE) || (s == CAPTURE);
  endfunction
endpackage

// File: rtl/calc_tick_cnt.sv
// Loadable up-counter that wraps at 'limit' and flags the terminal count.
module calc_tick_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/calc_sequencer.sv
// Operand/operation sequencer for the 4-bit add/sub datapath.
// Define CALC_CHAIN_EN to make enter in SHOW reuse the result as operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int BLINK_DIV  = 25000000,
  parameter int W          = CALC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         op_sub,
  input  logic         signed_mode,
  input  logic         btn_enter,
  input  logic         btn_clear,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         dp_sub,
  output logic         dp_rc,
  input  logic [W-1:0] dp_sum,
  input  logic         dp_valid,
  output logic [W-1:0] result,
  output logic         result_neg,
  output logic         result_ok,
  output logic         err,
  output logic         err_blink,
  output logic         busy
);
  calc_state_t state_q, state_d;
  logic [W-1:0] reg_a_q, reg_a_d;
  logic [W-1:0] reg_b_q, reg_b_d;
  logic         sub_q, sub_d;
  logic         rc_q, rc_d;
  logic [W-1:0] result_q, result_d;
  logic         result_rc_q, result_rc_d;
  logic         result_ok_q, result_ok_d;
  logic         err_q, err_d;
  logic         err_blink_q, err_blink_d;
  logic         busy_q, busy_d;

  logic settle_load;
  logic settle_tc;
  logic blink_tc;

  calc_tick_cnt #(.WIDTH(SETTLE_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (btn_clear),
    .load     (settle_load),
    .load_val ('0),
    .en       (state_q == ISSUE),
    .limit    (SETTLE_W'(SETTLE_CYC - 1)),
    .tc       (settle_tc)
  );

  // Held at zero outside ERR so each error episode starts a fresh half-period.
  calc_tick_cnt #(.WIDTH(CNT_W)) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != ERR),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q == ERR),
    .limit    (CNT_W'(BLINK_DIV - 1)),
    .tc       (blink_tc)
  );

  always_comb begin
    state_d     = state_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    sub_d       = sub_q;
    rc_d        = rc_q;
    result_d    = result_q;
    result_rc_d = result_rc_q;
    settle_load = 1'b0;

    if (btn_clear) begin
      state_d     = GET_A;
      reg_a_d     = '0;
      reg_b_d     = '0;
      result_d    = '0;
      result_rc_d = 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (btn_enter) begin
            reg_a_d = sw;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (btn_enter) begin
            reg_b_d     = sw;
            sub_d       = op_sub;
            rc_d        = signed_mode;
            settle_load = 1'b1;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (settle_tc) state_d = CAPTURE;
        end
        CAPTURE: begin
          result_d    = dp_sum;
          result_rc_d = rc_q;
          state_d     = dp_valid ? SHOW : ERR;
        end
        SHOW: begin
          if (btn_enter) begin
`ifdef CALC_CHAIN_EN
            reg_a_d = result_q;
            state_d = GET_B;
`else
            state_d = GET_A;
`endif
          end
        end
        ERR: begin
          if (btn_enter) state_d = GET_A;
        end
        default: state_d = GET_A;
      endcase
    end

    busy_d = is_busy(state_d);
    err_d  = (state_d == ERR);
`ifdef CALC_CHAIN_EN
    // A chained operation keeps the previous result flagged good until it is replaced.
    result_ok_d = (state_d == SHOW) ||
                  (result_ok_q && !btn_clear && (state_d == GET_B || is_busy(state_d)));
`else
    result_ok_d = (state_d == SHOW);
`endif
    err_blink_d = (state_q == ERR && state_d == ERR) ? (err_blink_q ^ blink_tc) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      sub_q       <= 1'b0;
      rc_q        <= 1'b0;
      result_q    <= '0;
      result_rc_q <= 1'b0;
      result_ok_q <= 1'b0;
      err_q       <= 1'b0;
      err_blink_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      sub_q       <= sub_d;
      rc_q        <= rc_d;
      result_q    <= result_d;
      result_rc_q <= result_rc_d;
      result_ok_q <= result_ok_d;
      err_q       <= err_d;
      err_blink_q <= err_blink_d;
      busy_q      <= busy_d;
    end
  end

  assign dp_a       = reg_a_q;
  assign dp_b       = reg_b_q;
  assign dp_sub     = sub_q;
  assign dp_rc      = rc_q;
  assign result     = result_q;
  assign result_neg = result_rc_q & result_q[W-1];
  assign result_ok  = result_ok_q;
  assign err        = err_q;
  assign err_blink  = err_blink_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer with a behavioural datapath model.
// Honours CALC_CHAIN_EN to select the expected SHOW/enter behaviour.
module tb_calc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sub, signed_mode, btn_enter, btn_clear;
  logic [3:0] dp_a, dp_b, dp_sum, result;
  logic       dp_sub, dp_rc, dp_valid;
  logic       result_neg, result_ok, err, err_blink, busy;
  logic       valid_flip;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.SETTLE_CYC(2), .BLINK_DIV(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sub(op_sub), .signed_mode(signed_mode),
    .btn_enter(btn_enter), .btn_clear(btn_clear),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_rc(dp_rc),
    .dp_sum(dp_sum), .dp_valid(dp_valid),
    .result(result), .result_neg(result_neg), .result_ok(result_ok),
    .err(err), .err_blink(err_blink), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference datapath: add/sub with unsigned carry/borrow or signed overflow check.
  logic [4:0] wide;
  logic       ok_model;
  always_comb begin
    wide     = dp_sub ? ({1'b0, dp_a} - {1'b0, dp_b}) : ({1'b0, dp_a} + {1'b0, dp_b});
    dp_sum   = wide[3:0];
    ok_model = 1'b1;
    if (dp_rc) begin
      if (!dp_sub && dp_a[3] == dp_b[3] && wide[3] != dp_a[3]) ok_model = 1'b0;
      if (dp_sub && dp_a[3] != dp_b[3] && wide[3] != dp_a[3]) ok_model = 1'b0;
    end else begin
      ok_model = !wide[4];
    end
    dp_valid = ok_model ^ valid_flip;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enter(input logic [3:0] v);
    sw = v;
    btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
  endtask

  task automatic clear();
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; op_sub = 1'b0; signed_mode = 1'b0;
    btn_enter = 1'b0; btn_clear = 1'b0; valid_flip = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    chk("rst_result", result, 4'h0);
    chk("rst_ok", {3'b0, result_ok}, 4'h0);
    chk("rst_err", {3'b0, err}, 4'h0);
    chk("rst_busy", {3'b0, busy}, 4'h0);
    chk("rst_blink", {3'b0, err_blink}, 4'h0);
    chk("rst_dp_a", dp_a, 4'h0);

    // 3 + 4 unsigned; result lands SETTLE_CYC+2 edges after the B enter
    enter(4'd3);
    op_sub = 1'b0; signed_mode = 1'b0;
    enter(4'd4);
    chk("add_busy1", {3'b0, busy}, 4'h1);
    chk("add_dp_a", dp_a, 4'd3);
    chk("add_dp_b", dp_b, 4'd4);
    chk("add_ok1", {3'b0, result_ok}, 4'h0);
    tick();
    chk("add_busy2", {3'b0, busy}, 4'h1);
    tick();
    chk("add_busy3", {3'b0, busy}, 4'h1);
    chk("add_ok3", {3'b0, result_ok}, 4'h0);
    tick();
    chk("add_result", result, 4'b0111);
    chk("add_ok", {3'b0, result_ok}, 4'h1);
    chk("add_busy_done", {3'b0, busy}, 4'h0);
    chk("add_neg", {3'b0, result_neg}, 4'h0);

`ifdef CALC_CHAIN_EN
    enter(4'd0);
    chk("chain_dp_a", dp_a, 4'd7);
    chk("chain_ok_hold", {3'b0, result_ok}, 4'h1);
    op_sub = 1'b0; signed_mode = 1'b0;
    enter(4'd2);
    ticks(3);
    chk("chain_result", result, 4'b1001);
    chk("chain_ok", {3'b0, result_ok}, 4'h1);
    chk("chain_err", {3'b0, err}, 4'h0);
`else
    enter(4'd9);
    chk("show_enter_ok", {3'b0, result_ok}, 4'h0);
    chk("show_enter_dp_a", dp_a, 4'd3);
    chk("show_enter_keep", result, 4'd7);
`endif
    clear();
    chk("clr_result", result, 4'h0);
    chk("clr_ok", {3'b0, result_ok}, 4'h0);

    // 2 - 5 signed = -3
    enter(4'd2);
    op_sub = 1'b1; signed_mode = 1'b1;
    enter(4'd5);
    ticks(3);
    chk("sub_result", result, 4'b1101);
    chk("sub_neg", {3'b0, result_neg}, 4'h1);
    chk("sub_ok", {3'b0, result_ok}, 4'h1);
    clear();
    chk("sub_clr_neg", {3'b0, result_neg}, 4'h0);

    // 7 + 1 signed overflows -> ERR with blink every 4 cycles
    enter(4'd7);
    op_sub = 1'b0; signed_mode = 1'b1;
    enter(4'd1);
    ticks(3);
    chk("ovf_err", {3'b0, err}, 4'h1);
    chk("ovf_ok", {3'b0, result_ok}, 4'h0);
    chk("ovf_result", result, 4'b1000);
    chk("ovf_blink0", {3'b0, err_blink}, 4'h0);
    ticks(3);
    chk("ovf_blink3", {3'b0, err_blink}, 4'h0);
    tick();
    chk("ovf_blink4", {3'b0, err_blink}, 4'h1);
    ticks(3);
    chk("ovf_blink7", {3'b0, err_blink}, 4'h1);
    tick();
    chk("ovf_blink8", {3'b0, err_blink}, 4'h0);
    enter(4'd0);
    chk("ovf_exit_err", {3'b0, err}, 4'h0);
    chk("ovf_exit_blink", {3'b0, err_blink}, 4'h0);
    chk("ovf_exit_keep", result, 4'b1000);

    // clear and enter together in GET_B: clear wins
    enter(4'd5);
    chk("cw_dp_a_pre", dp_a, 4'd5);
    sw = 4'd9; btn_enter = 1'b1; btn_clear = 1'b1;
    tick();
    btn_enter = 1'b0; btn_clear = 1'b0;
    chk("cw_dp_a", dp_a, 4'h0);
    chk("cw_busy", {3'b0, busy}, 4'h0);
    chk("cw_result", result, 4'h0);
    ticks(4);
    chk("cw_no_cap_ok", {3'b0, result_ok}, 4'h0);
    chk("cw_no_cap_err", {3'b0, err}, 4'h0);
    enter(4'd6);
    chk("cw_in_get_a", dp_a, 4'd6);
    chk("cw_dp_b", dp_b, 4'h0);

    // reset mid-ISSUE aborts with no capture
    op_sub = 1'b0; signed_mode = 1'b0;
    enter(4'd1);
    chk("ri_busy", {3'b0, busy}, 4'h1);
    rst_n = 1'b0;
    tick();
    chk("ri_busy0", {3'b0, busy}, 4'h0);
    chk("ri_dp_a", dp_a, 4'h0);
    chk("ri_dp_b", dp_b, 4'h0);
    chk("ri_ok", {3'b0, result_ok}, 4'h0);
    rst_n = 1'b1;
    valid_flip = 1'b1;
    ticks(5);
    chk("ri_late_ok", {3'b0, result_ok}, 4'h0);
    chk("ri_late_err", {3'b0, err}, 4'h0);
    chk("ri_late_result", result, 4'h0);
    valid_flip = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
